regwrite_arbiter: RTL

REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

---
 rtl/regwrite_arbiter_if.sv | 26 ++
 rtl/regwrite_arbiter.sv | 115 +++++++++++
 2 files changed

// File: rtl/regwrite_arbiter_if.sv
// Bundles the processor writeback, accelerometer sample and register-file write buses.
// master drives the CPU and sample inputs; slave is the arbiter that owns the register-file port.
interface regwrite_arbiter_if;
   logic        cpu_we;
   logic [4:0]  cpu_rd;
   logic [31:0] cpu_data;
   logic        smp_valid;
   logic [15:0] smp_y;
   logic [14:0] smp_xyz;
   logic        rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_data;
   logic        stall_req;
   logic [7:0]  drop_cnt;
   logic        busy;

   modport master (
      output cpu_we, cpu_rd, cpu_data, smp_valid, smp_y, smp_xyz,
      input  rf_we, rf_rd, rf_data, stall_req, drop_cnt, busy
   );

   modport slave (
      input  cpu_we, cpu_rd, cpu_data, smp_valid, smp_y, smp_xyz,
      output rf_we, rf_rd, rf_data, stall_req, drop_cnt, busy
   );
endinterface

// File: rtl/regwrite_arbiter.sv
// Merges accelerometer samples into the register-file write port; the CPU always wins, with zero latency.
// Samples wait in a 2-deep FIFO (overflow dropped and counted); Y lands 2 cycles after smp_valid when unblocked.
module regwrite_arbiter #(
   parameter int unsigned Y_REG        = 28,
   parameter int unsigned XYZ_REG      = 29,
   parameter int unsigned STARVE_LIMIT = 64
) (
   input logic              clock,
   input logic              reset,
   regwrite_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, WR_Y, WR_XYZ} state_t;

   localparam logic [4:0] Y_IDX      = 5'(Y_REG);
   localparam logic [4:0] XYZ_IDX    = 5'(XYZ_REG);
   localparam logic [7:0] STARVE_THR = 8'(STARVE_LIMIT - 1);

   state_t      state, state_next;
   logic [30:0] fifo_mem [2];
   logic        wr_ptr, rd_ptr;
   logic [1:0]  fifo_cnt;
   logic [30:0] hold;
   logic [7:0]  starve_cnt;
   logic        fifo_empty, fifo_full, push, pop, drop;
   logic        accel_wr, blocked;

   assign fifo_empty = (fifo_cnt == 2'd0);
   assign fifo_full  = (fifo_cnt == 2'd2);
   assign pop        = (state == IDLE) && !fifo_empty;
   // A pop frees a slot in the same cycle, so a full FIFO still accepts the push.
   assign push       = bus.smp_valid && (!fifo_full || pop);
   assign drop       = bus.smp_valid && !push;
   assign blocked    = bus.cpu_we && (state != IDLE);
   assign bus.busy   = !fifo_empty || (state != IDLE);

   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr] <= {bus.smp_y, bus.smp_xyz};
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         fifo_cnt     <= 2'd0;
         hold         <= '0;
         bus.drop_cnt <= 8'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop) begin
            rd_ptr <= ~rd_ptr;
            hold   <= fifo_mem[rd_ptr];
         end
         fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
         if (drop && bus.drop_cnt != 8'hFF) bus.drop_cnt <= bus.drop_cnt + 8'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         starve_cnt    <= 8'd0;
         bus.stall_req <= 1'b0;
      end else begin
         state <= state_next;
         if (state == IDLE || accel_wr)
            starve_cnt <= 8'd0;
         else if (blocked && starve_cnt != 8'hFF)
            starve_cnt <= starve_cnt + 8'd1;
         // Set on the blocked cycle that brings the counter to the limit; held until the write lands.
         if (state == IDLE || accel_wr)
            bus.stall_req <= 1'b0;
         else if (blocked && starve_cnt >= STARVE_THR)
            bus.stall_req <= 1'b1;
      end
   end

   always_comb begin
      state_next  = state;
      accel_wr    = 1'b0;
      bus.rf_we   = 1'b0;
      bus.rf_rd   = 5'd0;
      bus.rf_data = 32'd0;
      case (state)
         IDLE: begin
            if (!fifo_empty) state_next = WR_Y;
         end
         WR_Y: begin
            if (!bus.cpu_we) begin
               state_next  = WR_XYZ;
               accel_wr    = 1'b1;
               bus.rf_we   = 1'b1;
               bus.rf_rd   = Y_IDX;
               bus.rf_data = {{16{hold[30]}}, hold[30:15]};
            end
         end
         WR_XYZ: begin
            if (!bus.cpu_we) begin
               state_next  = IDLE;
               accel_wr    = 1'b1;
               bus.rf_we   = 1'b1;
               bus.rf_rd   = XYZ_IDX;
               bus.rf_data = {17'd0, hold[14:0]};
            end
         end
         default: state_next = IDLE;
      endcase
      if (bus.cpu_we) begin
         bus.rf_we   = 1'b1;
         bus.rf_rd   = bus.cpu_rd;
         bus.rf_data = bus.cpu_data;
      end
   end

endmodule
